// File: rtl/frame_sync_deser.sv
// frame_sync_deser: frame synchroniser and payload deserialiser for the CDR bit stream.
//
// It searches the qualified serial stream (d_bb when sample_en = 1) bit by bit for SYNC_PATTERN.
// It confirms alignment over CONFIRM_N consecutive syncs, then emits DATA_W-bit payload words
// while locked. It flywheels through isolated sync misses and falls back to HUNT after MISS_N
// consecutive misses.
//
// Optional build macro FSYNC_INV_EN: HUNT also accepts ~SYNC_PATTERN. In that case every later
// bit is complemented, and the polarity_inv output port is added.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   sample_en    bit strobe from the CDR, qualifies d_bb
//   d_bb         recovered bit
//   word_out     deserialised payload word, MSB = first-received bit
//   word_valid   1-cycle pulse when word_out is new
//   frame_start  with word_valid, marks the first payload word of a frame
//   locked       high while state == LOCK
//   state        0 = HUNT, 1 = VERIFY, 2 = LOCK
//   sync_err_cnt sync misses seen in LOCK, saturating
//   polarity_inv (FSYNC_INV_EN only) stream is being complemented
module frame_sync_deser #(
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       SYNC_W        = 16,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN  = 16'hF628,
  parameter int unsigned       PAYLOAD_WORDS = 4,
  parameter int unsigned       CONFIRM_N     = 2,
  parameter int unsigned       MISS_N        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              d_bb,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              frame_start,
  output logic              locked,
  output logic [1:0]        state,
  output logic [15:0]       sync_err_cnt
`ifdef FSYNC_INV_EN
  ,
  output logic              polarity_inv
`endif
);

  localparam int unsigned PayloadBits = PAYLOAD_WORDS * DATA_W;
  localparam int unsigned FrameBits   = SYNC_W + PayloadBits;
  localparam int unsigned PosW        = $clog2(FrameBits);
  localparam int unsigned ConfW       = $clog2(CONFIRM_N + 1);
  localparam int unsigned MissW       = $clog2(MISS_N + 1);
  localparam int unsigned FillW       = $clog2(SYNC_W + 1);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLock   = 2'd2
  } state_t;

  state_t            fsm;
  // Only SYNC_W-1 history bits are stored: the oldest bit of sr_next is never needed again.
  logic [SYNC_W-2:0] sr;
  logic [PosW-1:0]   pos;
  logic [ConfW-1:0]  conf_cnt;
  logic [MissW-1:0]  miss_cnt;
  logic [FillW-1:0]  fill_cnt;
  logic              inv;

  logic              bit_in;
  logic [SYNC_W-1:0] sr_next;
  logic              true_match;
  logic              inv_match;
  logic              filled;
  logic              hunt_hit;
  logic              at_check;
  logic              word_end;
  logic              hunt_entry;

  assign bit_in     = d_bb ^ inv;
  assign sr_next    = {sr, bit_in};
  assign true_match = (sr_next == SYNC_PATTERN);
`ifdef FSYNC_INV_EN
  assign inv_match  = (sr_next == ~SYNC_PATTERN);
`else
  assign inv_match  = 1'b0;
`endif
  // The current bit counts toward the SYNC_W fresh bits needed before a HUNT match.
  assign filled     = (fill_cnt >= FillW'(SYNC_W - 1));
  assign hunt_hit   = filled && (true_match || inv_match);
  assign at_check   = (pos == PosW'(FrameBits - 1));
  assign word_end   = (32'(pos) < PayloadBits) && (((32'(pos) + 1) % DATA_W) == 0);
  assign hunt_entry = sample_en && at_check && !true_match &&
                      ((fsm == StVerify) ||
                       ((fsm == StLock) && (miss_cnt == MissW'(MISS_N - 1))));

  assign state = fsm;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= StHunt;
      sr           <= '0;
      pos          <= '0;
      conf_cnt     <= '0;
      miss_cnt     <= '0;
      fill_cnt     <= '0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (sample_en) begin
        sr  <= sr_next[SYNC_W-2:0];
        pos <= at_check ? '0 : pos + 1'b1;
        unique case (fsm)
          StHunt: begin
            if (fill_cnt != FillW'(SYNC_W)) fill_cnt <= fill_cnt + 1'b1;
            if (hunt_hit) begin
              fsm      <= StVerify;
              pos      <= '0;
              conf_cnt <= ConfW'(1);
            end
          end
          StVerify: begin
            if (at_check) begin
              if (true_match) begin
                conf_cnt <= conf_cnt + 1'b1;
                if (conf_cnt == ConfW'(CONFIRM_N - 1)) begin
                  fsm      <= StLock;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                fsm      <= StHunt;
                fill_cnt <= '0;
              end
            end
          end
          StLock: begin
            if (word_end) begin
              word_out    <= sr_next[DATA_W-1:0];
              word_valid  <= 1'b1;
              frame_start <= (pos == PosW'(DATA_W - 1));
            end
            if (at_check) begin
              if (true_match) begin
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
                if (sync_err_cnt != 16'hFFFF) sync_err_cnt <= sync_err_cnt + 16'd1;
                if (hunt_entry) begin
                  fsm      <= StHunt;
                  locked   <= 1'b0;
                  fill_cnt <= '0;
                end
              end
            end
          end
          default: begin
            fsm      <= StHunt;
            locked   <= 1'b0;
            fill_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef FSYNC_INV_EN
  // Polarity is decided by the HUNT match and held until alignment is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv <= 1'b0;
    end else if (hunt_entry) begin
      inv <= 1'b0;
    end else if (sample_en && (fsm == StHunt) && hunt_hit && !true_match) begin
      inv <= 1'b1;
    end
  end

  assign polarity_inv = inv;
`else
  assign inv = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sync_deser.sv
// Directed testbench for frame_sync_deser: reset, clean acquisition, flywheel, VERIFY failure,
// irregular strobes and (with FSYNC_INV_EN) inverted-polarity acquisition.
module tb_frame_sync_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        d_bb;
  logic [7:0]  word_out;
  logic        word_valid;
  logic        frame_start;
  logic        locked;
  logic [1:0]  state;
  logic [15:0] sync_err_cnt;
`ifdef FSYNC_INV_EN
  logic        polarity_inv;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_w[$];
  logic       got_fs[$];
  logic       en_at_edge = 1'b0;

  always #5 clk = ~clk;

  frame_sync_deser dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .d_bb         (d_bb),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .frame_start  (frame_start),
    .locked       (locked),
    .state        (state),
    .sync_err_cnt (sync_err_cnt)
`ifdef FSYNC_INV_EN
    ,
    .polarity_inv (polarity_inv)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) en_at_edge <= sample_en;

  // Capture words; each word_valid must follow a strobe on the immediately preceding edge.
  always @(negedge clk) begin
    if (!rst && word_valid) begin
      got_w.push_back(word_out);
      got_fs.push_back(frame_start);
      check("wv_latency", 32'(en_at_edge), 32'd1);
    end
  end

  task automatic send_bits(input logic [31:0] v, input int n, input bit irr);
    for (int i = n - 1; i >= 0; i--) begin
      int gap;
      gap       = irr ? int'($urandom_range(1, 5)) : 1;
      sample_en = 1'b1;
      d_bb      = v[i];
      @(posedge clk); #1;
      sample_en = 1'b0;
      d_bb      = ~v[i];
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_en = i[0];
      d_bb      = 1'b1;
      @(posedge clk); #1;
      check("reset_outs", {3'b0, word_out, word_valid, frame_start, locked, state, sync_err_cnt},
            32'd0);
    end
    rst       = 1'b0;
    sample_en = 1'b0;
    @(posedge clk); #1;
    check("post_reset_outs", {3'b0, word_out, word_valid, frame_start, locked, state,
          sync_err_cnt}, 32'd0);
    got_w.delete();
    got_fs.delete();
  endtask

  function automatic logic [7:0] get_w(input int i);
    return (i < got_w.size()) ? got_w[i] : 8'hXX;
  endfunction

  function automatic logic get_fs(input int i);
    return (i < got_fs.size()) ? got_fs[i] : 1'bx;
  endfunction

  task automatic check_frame(input int base, input logic [31:0] exp4);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = exp4[31 - 8 * k -: 8];
      check("word", 32'(get_w(base + k)), 32'(e));
      check("frame_start", 32'(get_fs(base + k)), (k == 0) ? 32'd1 : 32'd0);
    end
  endtask

  // Clean stream: two confirming syncs then two payload frames that must be emitted.
  task automatic acquire(input bit irr);
    send_bits(32'hF628, 16, irr);
    check("state_after_sync1", 32'(state), 32'd1);
    send_bits(32'h11223344, 32, irr);
    send_bits(32'hF628, 16, irr);
    check("state_after_sync2", 32'(state), 32'd2);
    check("locked_after_sync2", 32'(locked), 32'd1);
    check("no_verify_words", got_w.size(), 32'd0);
    send_bits(32'h55667788, 32, irr);
    send_bits(32'hF628, 16, irr);
    send_bits(32'h99AABBCC, 32, irr);
    check("word_count", got_w.size(), 32'd8);
    check_frame(0, 32'h55667788);
    check_frame(4, 32'h99AABBCC);
    check("err_cnt_clean", 32'(sync_err_cnt), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sample_en = 1'b0;
    d_bb      = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;

    // Reset and clean acquisition
    do_reset();
    acquire(1'b0);

    // Flywheel: two misses then a good sync keep LOCK
    got_w.delete();
    got_fs.delete();
    send_bits(32'hF629, 16, 1'b0);
    check("err_after_miss1", 32'(sync_err_cnt), 32'd1);
    send_bits(32'hA1A2A3A4, 32, 1'b0);
    send_bits(32'hF629, 16, 1'b0);
    check("state_after_miss2", 32'(state), 32'd2);
    send_bits(32'hB1B2B3B4, 32, 1'b0);
    send_bits(32'hF628, 16, 1'b0);
    send_bits(32'hC1C2C3C4, 32, 1'b0);
    check("fly_locked", 32'(locked), 32'd1);
    check("fly_err_cnt", 32'(sync_err_cnt), 32'd2);
    check("fly_word_count", got_w.size(), 32'd12);
    check_frame(0, 32'hA1A2A3A4);
    check_frame(4, 32'hB1B2B3B4);
    check_frame(8, 32'hC1C2C3C4);
    // Three consecutive misses drop lock
    send_bits(32'hF629, 16, 1'b0);
    send_bits(32'hD1D2D3D4, 32, 1'b0);
    send_bits(32'hF629, 16, 1'b0);
    check("state_after_2of3", 32'(state), 32'd2);
    send_bits(32'hE1E2E3E4, 32, 1'b0);
    send_bits(32'hF629, 16, 1'b0);
    check("state_after_3miss", 32'(state), 32'd0);
    check("locked_after_3miss", 32'(locked), 32'd0);
    check("err_after_3miss", 32'(sync_err_cnt), 32'd5);

    // Mid-frame reset discards alignment
    send_bits(32'hF628, 16, 1'b0);
    send_bits(32'h1122, 16, 1'b0);
    do_reset();

    // VERIFY failure then reacquire
    send_bits(32'hF628, 16, 1'b0);
    check("vf_state_verify", 32'(state), 32'd1);
    send_bits(32'h11223344, 32, 1'b0);
    send_bits(32'hF629, 16, 1'b0);
    check("vf_state_hunt", 32'(state), 32'd0);
    check("vf_err_cnt", 32'(sync_err_cnt), 32'd0);
    send_bits(32'h11223344, 32, 1'b0);
    send_bits(32'hF628, 16, 1'b0);
    check("vf_state_verify2", 32'(state), 32'd1);
    send_bits(32'h55667788, 32, 1'b0);
    send_bits(32'hF628, 16, 1'b0);
    check("vf_state_lock", 32'(state), 32'd2);
    check("vf_no_words", got_w.size(), 32'd0);
    send_bits(32'h99AABBCC, 32, 1'b0);
    check("vf_word_count", got_w.size(), 32'd4);
    check_frame(0, 32'h99AABBCC);

    // Irregular strobe spacing
    do_reset();
    acquire(1'b1);

    // Bit-inverted stream
    do_reset();
    send_bits(~32'h0000F628, 16, 1'b0);
    send_bits(~32'h11223344, 32, 1'b0);
    send_bits(~32'h0000F628, 16, 1'b0);
    send_bits(~32'h55667788, 32, 1'b0);
`ifdef FSYNC_INV_EN
    check("inv_polarity", 32'(polarity_inv), 32'd1);
    check("inv_state", 32'(state), 32'd2);
    check("inv_word_count", got_w.size(), 32'd4);
    check_frame(0, 32'h55667788);
`else
    check("inv_state_hunt", 32'(state), 32'd0);
    check("inv_no_words", got_w.size(), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sync_deser.md
Name: frame_sync_deser

Overview:
- Consumes the CDR's recovered bit stream: hard decision `d_bb`, qualified by the 1-cycle symbol strobe `sample_en`.
- Finds a fixed sync pattern in the serial stream, confirms frame alignment, and deserializes the payload into DATA_W-bit words.
- Flywheels through isolated sync errors and drops lock after MISS_N consecutive misses.
- Sits directly downstream of the CDR, in the same clock domain; its word output feeds the framing/consumer logic.

Parameters:
- DATA_W, 8, payload word width in bits (2..16).
- SYNC_W, 16, sync pattern width in bits; must be >= DATA_W.
- SYNC_PATTERN, 16'hF628, sync word, sent MSB first.
- PAYLOAD_WORDS, 4, payload words per frame (>= 1).
- CONFIRM_N, 2, consecutive sync matches required to reach LOCK, counting the initial HUNT match (>= 2).
- MISS_N, 3, consecutive sync misses in LOCK that force a return to HUNT (>= 1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- sample_en, input, 1, bit strobe from the CDR; `d_bb` is valid only when this is 1.
- d_bb, input, 1, recovered bit.
- word_out, output, DATA_W, deserialized payload word, MSB = first-received bit.
- word_valid, output, 1, 1-cycle pulse when `word_out` is new.
- frame_start, output, 1, high together with `word_valid` for the first payload word of each frame.
- locked, output, 1, high while state == LOCK.
- state, output, 2, 0 = HUNT, 1 = VERIFY, 2 = LOCK.
- sync_err_cnt, output, 16, count of sync misses while in LOCK; saturates at 16'hFFFF.

Behaviour:
- Reset:
  - All outputs are 0 and state = HUNT.
  - Shift register, pos, conf_cnt and miss_cnt are cleared.
  - Reset applied mid-frame fully discards alignment.
- Idle cycles:
  - Nothing advances on cycles with `sample_en` = 0.
  - `word_valid` and `frame_start` are 0 on those cycles.
- Shift register and timing:
  - On `sample_en`: sr_next = {sr[SYNC_W-2:0], d_bb}; sr <= sr_next.
  - FRAME_BITS = SYNC_W + PAYLOAD_WORDS*DATA_W.
  - pos counts the bits received since the end of the last sync.
  - Payload occupies pos 0..PAYLOAD_WORDS*DATA_W-1.
  - The sync check is at pos == FRAME_BITS-1, comparing sr_next to SYNC_PATTERN; pos then wraps to 0.
- HUNT:
  - Bit-by-bit search.
  - If sr_next == SYNC_PATTERN: go to VERIFY, set pos <= 0, conf_cnt <= 1.
  - A match also requires that at least SYNC_W bits have been shifted since reset/HUNT entry.
- VERIFY:
  - No words are emitted.
  - At a sync check with a match: conf_cnt++. When conf_cnt reaches CONFIRM_N, go to LOCK and clear miss_cnt.
  - At a sync check with a miss: go to HUNT, with no error count.
- LOCK:
  - Emitting words: on a `sample_en` with pos in the payload region and (pos+1) mod DATA_W == 0, register word_out <= sr_next[DATA_W-1:0] and pulse `word_valid` in the next clk cycle. Latency is 1 clk after the strobe that carries the word's last bit.
  - `frame_start` accompanies the word completed at pos == DATA_W-1.
  - Sync check, match: miss_cnt <= 0.
  - Sync check, miss: miss_cnt++ and sync_err_cnt++ (saturating). If the new miss_cnt == MISS_N, go to HUNT; `locked` falls the following cycle.
  - Payload is still emitted in frames that follow a missed sync, while LOCK holds (flywheel).
- HUNT re-entry:
  - The shift-register contents are kept.
  - The search resumes on the next strobe.
  - `sync_err_cnt` is not cleared (only `rst` clears it).
- Widths:
  - pos is $clog2(FRAME_BITS) bits.
  - conf_cnt and miss_cnt are sized to their maxima.
  - No counter may wrap except pos, at FRAME_BITS-1.
- Output registering: all outputs are registered; `locked` and `state` are consistent in the same cycle.

Optional Feature:
- Macro: FSYNC_INV_EN.
- With the macro defined:
  - HUNT also matches ~SYNC_PATTERN. An inverted match sets an internal inv flag.
  - While inv = 1, every subsequent bit is complemented before shifting.
  - inv is cleared on `rst` and on every HUNT entry.
  - Added output port: polarity_inv (1 bit) = inv.
- Without the macro: only the true pattern is matched, and the polarity_inv port does not exist.

Test Plan:
- Reset: assert `rst` for 3 clk while `sample_en` toggles → all outputs 0, state = 0 throughout and after release.
- Clean acquisition: strobe every 2 clk (as from the CDR) with stream F628, 11 22 33 44, F628, 55 66 77 88, F628, 99 AA BB CC.
  - state = 1 after the first sync, and 2 at the end of the second sync.
  - 11 22 33 44 are not emitted.
  - Words 55, 66, 77, 88 are emitted with `frame_start` on 55, then 99..CC follow.
  - `sync_err_cnt` = 0.
- Flywheel: in LOCK, corrupt 2 consecutive syncs (F629) then send a good one → stays locked, payload is still emitted, `sync_err_cnt` = 2. Then corrupt 3 consecutive syncs → state = 0 after the third, `sync_err_cnt` = 5.
- VERIFY failure: after the first F628, send a corrupted second sync → state returns 0→1→0, no `word_valid`, `sync_err_cnt` = 0. Then two good frames → LOCK.
- Irregular strobes: the same stream as the clean-acquisition test with random `sample_en` gaps of 1–5 clk → an identical word sequence, with each `word_valid` exactly 1 clk after the completing strobe.
- FSYNC_INV_EN: send a bit-inverted version of the clean-acquisition stream → polarity_inv = 1, words 55..88 are emitted non-inverted. Without the macro, the same stimulus never leaves HUNT.
